// File: rtl/lfsr_rng_sched.sv
// lfsr_rng_sched: round-robin scheduler that shares one 4-bit Fibonacci LFSR
// (x^4+x^3+1, period 15) between N_REQ requesters. Each grant hands over the
// current LFSR value with a one-cycle grant/valid strobe. The LFSR then shifts
// STEPS times before the next grant can be issued.
// Optional feature: define LFSR_FREERUN_EN to let the LFSR also shift on every
// idle cycle, so the delivered values depend on request timing.
module lfsr_rng_sched #(
  parameter int         N_REQ = 4,
  parameter int         STEPS = 1,
  parameter logic [3:0] SEED  = 4'b0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [3:0]       seed_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [3:0]       rnd_o,
  output logic             rnd_valid_o,
  output logic             busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       lfsr_reg, lfsr_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [N_REQ-1:0] gnt_next;
  logic [3:0]       rnd_next;
  logic             valid_next;
  logic             busy_next;

  logic [N_REQ-1:0] rot_req;
  logic [PTR_W-1:0] win_idx;
  logic [3:0]       lfsr_shift;
  logic [3:0]       seed_sel;
  int               win_off;

  // (base + off) modulo N_REQ; base is always < N_REQ and off < N_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return sum[PTR_W-1:0];
  endfunction

  // Requests rotated so that bit 0 is the requester the pointer currently favours.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_req[gi] = req_i[wrap_add(ptr_reg, gi)];
    end
  endgenerate

  assign lfsr_shift = {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
  // An all-zero seed would lock the LFSR, so it is replaced by SEED.
  assign seed_sel   = (seed_i == 4'b0000) ? SEED : seed_i;

  // Priority encode the rotated requests: lowest set offset wins.
  always_comb begin
    win_off = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) win_off = i;
    end
    win_idx = wrap_add(ptr_reg, win_off);
  end

  // Next-state, LFSR sequencing and registered-output values.
  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt_next   = '0;
    rnd_next   = rnd_o;
    valid_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (seed_load) begin
          lfsr_next = seed_sel;
        end else if (|req_i) begin
          gnt_next[win_idx] = 1'b1;
          rnd_next          = lfsr_reg;
          valid_next        = 1'b1;
          lfsr_next         = lfsr_shift;
          ptr_next          = wrap_add(win_idx, 1);
          if (STEPS > 1) begin
            state_next = STEP;
            cnt_next   = 4'(STEPS - 1);
          end
        end else begin
`ifdef LFSR_FREERUN_EN
          lfsr_next = lfsr_shift;
`else
          lfsr_next = lfsr_reg;
`endif
        end
      end
      STEP: begin
        if (seed_load) begin
          lfsr_next  = seed_sel;
          state_next = IDLE;
        end else begin
          lfsr_next = lfsr_shift;
          if (cnt_reg == 4'd1) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == STEP);
  end

  // State, LFSR and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      lfsr_reg    <= SEED;
      cnt_reg     <= 4'd0;
      ptr_reg     <= '0;
      gnt_o       <= '0;
      rnd_o       <= 4'd0;
      rnd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      gnt_o       <= gnt_next;
      rnd_o       <= rnd_next;
      rnd_valid_o <= valid_next;
      busy_o      <= busy_next;
    end
  end

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// tb_lfsr_rng_sched: directed vectors for lfsr_rng_sched with hand-computed
// expected values. u_dut uses STEPS=1, u_dut3 uses STEPS=3.
module tb_lfsr_rng_sched;

  logic       clk = 1'b0;
  // STEPS=1 instance signals
  logic       reset = 1'b1;
  logic       seed_load = 1'b0;
  logic [3:0] seed_i = 4'b0000;
  logic [3:0] req_i = 4'b0000;
  logic [3:0] gnt_o;
  logic [3:0] rnd_o;
  logic       rnd_valid_o;
  logic       busy_o;
  // STEPS=3 instance signals
  logic       reset3 = 1'b1;
  logic       seed_load3 = 1'b0;
  logic [3:0] seed3 = 4'b0000;
  logic [3:0] req3 = 4'b0000;
  logic [3:0] gnt3;
  logic [3:0] rnd3;
  logic       valid3;
  logic       busy3;

  int n_checks = 0;
  int n_pass   = 0;

  // Sequence from seed 0001 as listed for x^4+x^3+1.
  logic [3:0] seq_tbl [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  lfsr_rng_sched #(.N_REQ(4), .STEPS(1), .SEED(4'b0001)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .seed_load   (seed_load),
    .seed_i      (seed_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rnd_o       (rnd_o),
    .rnd_valid_o (rnd_valid_o),
    .busy_o      (busy_o)
  );

  lfsr_rng_sched #(.N_REQ(4), .STEPS(3), .SEED(4'b0001)) u_dut3 (
    .clk         (clk),
    .reset       (reset3),
    .seed_load   (seed_load3),
    .seed_i      (seed3),
    .req_i       (req3),
    .gnt_o       (gnt3),
    .rnd_o       (rnd3),
    .rnd_valid_o (valid3),
    .busy_o      (busy3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %s = %b", tag, got);
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_gnt", 8'(gnt_o), 8'h00);
    check("rst_rnd", 8'(rnd_o), 8'h00);
    check("rst_valid", 8'(rnd_valid_o), 8'h00);
    check("rst_busy", 8'(busy_o), 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    #1;
    // 1) reset then a single request
    do_reset();
    req_i = 4'b0001;
    tick();
    check("first_gnt", 8'(gnt_o), 8'h01);
    check("first_rnd", 8'(rnd_o), 8'h01);
    check("first_valid", 8'(rnd_valid_o), 8'h01);
    req_i = 4'b0000;
    tick();
    check("idle_gnt", 8'(gnt_o), 8'h00);
    check("idle_valid", 8'(rnd_valid_o), 8'h00);
    check("idle_rnd_hold", 8'(rnd_o), 8'h01);

    // 2) all four requesting: round-robin with back-to-back grants
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), 8'(gnt_o), 8'(exp_gnt[i]));
      check($sformatf("rr_rnd%0d", i), 8'(rnd_o), 8'(seq_tbl[i]));
    end
    req_i = 4'b0000;
    tick();

    // 3) zero seed is replaced by SEED, then an explicit seed
    seed_load = 1'b1;
    seed_i    = 4'b0000;
    tick();
    check("seed0_nogrant", 8'(gnt_o), 8'h00);
    seed_load = 1'b0;
    req_i     = 4'b0001;
    tick();
    check("seed0_rnd", 8'(rnd_o), 8'h01);
    req_i     = 4'b0000;
    seed_load = 1'b1;
    seed_i    = 4'b1010;
    tick();
    seed_load = 1'b0;
    req_i     = 4'b0001;
    tick();
    check("seedA_rnd0", 8'(rnd_o), 8'h0a);
    tick();
    check("seedA_rnd1", 8'(rnd_o), 8'h05);
    check("seedA_valid", 8'(rnd_valid_o), 8'h01);
    req_i = 4'b0000;
    tick();

    // 4) seed_load wins over a request in the same cycle
    seed_load = 1'b1;
    seed_i    = 4'b0011;
    req_i     = 4'b0010;
    tick();
    check("ld_req_gnt", 8'(gnt_o), 8'h00);
    check("ld_req_valid", 8'(rnd_valid_o), 8'h00);
    seed_load = 1'b0;
    tick();
    check("ld_req_gnt2", 8'(gnt_o), 8'h02);
    check("ld_req_rnd2", 8'(rnd_o), 8'h03);
    req_i = 4'b0000;

    // 5) period-15 wrap with a single requester
    do_reset();
    req_i = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("wrap_rnd%0d", i), 8'(rnd_o), 8'(seq_tbl[i % 15]));
      check($sformatf("wrap_nz%0d", i), 8'(rnd_o != 4'b0000), 8'h01);
    end
    req_i = 4'b0000;

    // 6) STEPS=3 instance: busy window, request ignored in STEP, reset mid-STEP
    reset3 = 1'b0;
    req3   = 4'b0001;
    tick();
    check("s3_gnt0", 8'(gnt3), 8'h01);
    check("s3_rnd0", 8'(rnd3), 8'h01);
    check("s3_busy0", 8'(busy3), 8'h01);
    tick();
    check("s3_gnt_step", 8'(gnt3), 8'h00);
    check("s3_busy1", 8'(busy3), 8'h01);
    tick();
    check("s3_gnt_end", 8'(gnt3), 8'h00);
    check("s3_busy2", 8'(busy3), 8'h00);
    tick();
    check("s3_gnt1", 8'(gnt3), 8'h01);
    check("s3_rnd1", 8'(rnd3), 8'h09);
    check("s3_busy3", 8'(busy3), 8'h01);
    reset3 = 1'b1;
    #1;
    check("s3_rst_busy", 8'(busy3), 8'h00);
    check("s3_rst_gnt", 8'(gnt3), 8'h00);
    check("s3_rst_rnd", 8'(rnd3), 8'h00);
    tick();
    reset3 = 1'b0;
    tick();
    check("s3_post_rst_rnd", 8'(rnd3), 8'h01);
    check("s3_post_rst_busy", 8'(busy3), 8'h01);
    // seed_load aborts STEP
    req3       = 4'b0000;
    seed_load3 = 1'b1;
    seed3      = 4'b0101;
    tick();
    check("s3_abort_busy", 8'(busy3), 8'h00);
    check("s3_abort_gnt", 8'(gnt3), 8'h00);
    seed_load3 = 1'b0;
    req3       = 4'b0001;
    tick();
    check("s3_abort_rnd", 8'(rnd3), 8'h05);
    check("s3_abort_valid", 8'(valid3), 8'h01);
    req3 = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
